// File: rtl/frame_tick_ctrl.sv
// ---------------------------------------------------------------------------
// frame_tick_ctrl
//
// Frame sequencer placed directly after a flex counter. It owns the counter's
// clear / count_enable / rollover_val and treats every rollover_flag seen in
// RUN as one bit-period tick. Ticks become per-bit shift_strobe pulses, a
// 0-based bit index and an end-of-frame pulse for the serial datapath.
//
// Optional feature macro: FRAME_TICK_CTRL_CONT_EN
//   defined   : DONE samples start and can chain straight into the next frame
//               (DONE's clear doubles as the counter load).
//   undefined : DONE always returns to IDLE.
//
// Ports
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous, active-high reset
//   start          in   level request to run a frame
//   abort          in   terminate the frame in progress (LOAD/RUN only)
//   period_val     in   ticks per bit, 1..2^N-1
//   bits_per_frame in   bits per frame, 1..2^N-1
//   rollover_flag  in   tick from the flex counter
//   clear          out  counter clear (LOAD, DONE)
//   count_enable   out  counter enable (RUN)
//   rollover_val   out  latched period for the counter
//   shift_strobe   out  one cycle per bit boundary (combinational on the tick)
//   bit_idx        out  index of the bit currently timing
//   frame_done     out  one-cycle pulse on normal completion
//   busy           out  high in LOAD, RUN, DONE
//   cfg_err        out  one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module frame_tick_ctrl #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] period_val,
    input  logic [NUM_CNT_BITS-1:0] bits_per_frame,
    input  logic                    rollover_flag,
    output logic                    clear,
    output logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    shift_strobe,
    output logic [NUM_CNT_BITS-1:0] bit_idx,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] period_q, period_d;
    logic [NUM_CNT_BITS-1:0] bits_q, bits_d;
    logic [NUM_CNT_BITS-1:0] bit_idx_q, bit_idx_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    clear_q, count_enable_q, frame_done_q, busy_q;

    logic cfg_ok;
    logic last_bit;

    assign cfg_ok   = (period_val != '0) && (bits_per_frame != '0);
    assign last_bit = (bit_idx_q == (bits_q - ONE));

    // Strobe is Mealy so the datapath shifts in the same cycle as the tick;
    // abort suppresses it, including on a coincident final tick.
    assign shift_strobe = (state_q == RUN) && rollover_flag && !abort;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        bits_d    = bits_q;
        bit_idx_d = bit_idx_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d   = LOAD;
                        period_d  = period_val;
                        bits_d    = bits_per_frame;
                        bit_idx_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rollover_flag) begin
                    // Final tick leaves bit_idx on the last bit.
                    if (last_bit) state_d = DONE;
                    else          bit_idx_d = bit_idx_q + ONE;
                end
            end
            DONE: begin
`ifdef FRAME_TICK_CTRL_CONT_EN
                if (start && cfg_ok) begin
                    // DONE already holds clear high, so skip LOAD.
                    state_d   = RUN;
                    period_d  = period_val;
                    bits_d    = bits_per_frame;
                    bit_idx_d = '0;
                end else begin
                    state_d   = IDLE;
                    cfg_err_d = start;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with
    // the state they describe without a decode stage after the flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            period_q       <= '0;
            bits_q         <= '0;
            bit_idx_q      <= '0;
            cfg_err_q      <= 1'b0;
            clear_q        <= 1'b0;
            count_enable_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            bits_q         <= bits_d;
            bit_idx_q      <= bit_idx_d;
            cfg_err_q      <= cfg_err_d;
            clear_q        <= (state_d == LOAD) || (state_d == DONE);
            count_enable_q <= (state_d == RUN);
            frame_done_q   <= (state_d == DONE);
            busy_q         <= (state_d != IDLE);
        end
    end

    assign clear        = clear_q;
    assign count_enable = count_enable_q;
    assign rollover_val = period_q;
    assign bit_idx      = bit_idx_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_frame_tick_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for frame_tick_ctrl. rollover_flag is driven directly to
// emulate the flex counter; expected values are worked out by hand from the
// frame timing (first tick period cycles after RUN entry, then every period).
// ---------------------------------------------------------------------------
module tb_frame_tick_ctrl;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] period_val = '0;
    logic [N-1:0] bits_per_frame = '0;
    logic         rollover_flag = 1'b0;
    logic         clear, count_enable, shift_strobe, frame_done, busy, cfg_err;
    logic [N-1:0] rollover_val, bit_idx;

    int n_tests = 0;
    int n_fail  = 0;

    frame_tick_ctrl #(.NUM_CNT_BITS(N)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .abort         (abort),
        .period_val    (period_val),
        .bits_per_frame(bits_per_frame),
        .rollover_flag (rollover_flag),
        .clear         (clear),
        .count_enable  (count_enable),
        .rollover_val  (rollover_val),
        .shift_strobe  (shift_strobe),
        .bit_idx       (bit_idx),
        .frame_done    (frame_done),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs; outputs checked after
    // this reflect the edge just taken plus the Mealy strobe for these inputs.
    task automatic cyc(input logic st, input logic ab, input logic fl);
        @(posedge CLK);
        #1;
        start = st;
        abort = ab;
        rollover_flag = fl;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".busy"},  32'(busy), 0);
        check({tag, ".clear"}, 32'(clear), 0);
        check({tag, ".ce"},    32'(count_enable), 0);
        check({tag, ".fd"},    32'(frame_done), 0);
    endtask

    // Runs one frame from the IDLE start cycle through the DONE cycle.
    task automatic run_frame(input int p, input int b, input logic hold, input logic perturb);
        int strobes;
        int exp_idx;
        logic fl;
        strobes = 0;
        period_val = N'(p);
        bits_per_frame = N'(b);
        cyc(1'b1, 1'b0, 1'b0);                      // IDLE, start presented
        check("start.busy", 32'(busy), 0);
        cyc(hold, 1'b0, 1'b0);                      // LOAD
        check("load.clear", 32'(clear), 1);
        check("load.ce",    32'(count_enable), 0);
        check("load.busy",  32'(busy), 1);
        check("load.idx",   32'(bit_idx), 0);
        check("load.rval",  32'(rollover_val), p);
        for (int k = 0; k <= p * b; k++) begin
            fl = (k > 0) && (k % p == 0);
            exp_idx = (k == 0) ? 0 : (k - 1) / p;
            if (perturb && k == 1) begin
                period_val = N'(p + 1);
                bits_per_frame = N'(b + 3);
            end
            if (perturb && k == p * b) begin
                period_val = N'(p);
                bits_per_frame = N'(b);
            end
            cyc(hold, 1'b0, fl);
            check("run.strobe", 32'(shift_strobe), 32'(fl));
            check("run.idx",    32'(bit_idx), exp_idx);
            check("run.ce",     32'(count_enable), 1);
            check("run.clear",  32'(clear), 0);
            check("run.fd",     32'(frame_done), 0);
            check("run.rval",   32'(rollover_val), p);
            if (shift_strobe) strobes++;
        end
        check("frame.strobes", strobes, b);
        cyc(hold, 1'b0, 1'b0);                      // DONE
        check("done.fd",     32'(frame_done), 1);
        check("done.clear",  32'(clear), 1);
        check("done.ce",     32'(count_enable), 0);
        check("done.busy",   32'(busy), 1);
        check("done.idx",    32'(bit_idx), b - 1);
        check("done.strobe", 32'(shift_strobe), 0);
    endtask

    initial begin
        // Reset state
        #2 RST = 1'b1;
        #1;
        chk_idle("rst");
        check("rst.idx",  32'(bit_idx), 0);
        check("rst.rval", 32'(rollover_val), 0);
        check("rst.err",  32'(cfg_err), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Normal frame, period 3, bits 4, with cfg inputs moving mid-frame
        run_frame(3, 4, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("n.after");

        // Period 1, bits 5: back-to-back strobes
        run_frame(1, 5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("p1.after");

        // Config errors: bits 0, then period 0
        bits_per_frame = '0;
        period_val = N'(3);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("err.b0.pulse", 32'(cfg_err), 1);
        chk_idle("err.b0");
        cyc(1'b0, 1'b0, 1'b0);
        check("err.b0.once", 32'(cfg_err), 0);
        period_val = '0;
        bits_per_frame = N'(2);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("err.p0.pulse", 32'(cfg_err), 1);
        chk_idle("err.p0");

        // Abort on the final tick: period 2, bits 2
        period_val = N'(2);
        bits_per_frame = N'(2);
        cyc(1'b1, 1'b0, 1'b0);                      // IDLE
        cyc(1'b0, 1'b0, 1'b0);                      // LOAD
        cyc(1'b0, 1'b0, 1'b0);                      // RUN k0
        cyc(1'b0, 1'b0, 1'b0);                      // k1
        cyc(1'b0, 1'b0, 1'b1);                      // k2 tick
        check("ab.strobe1", 32'(shift_strobe), 1);
        cyc(1'b0, 1'b0, 1'b0);                      // k3
        check("ab.idx", 32'(bit_idx), 1);
        cyc(1'b0, 1'b1, 1'b1);                      // k4 final tick + abort
        check("ab.strobe2", 32'(shift_strobe), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("ab.next");
        cyc(1'b0, 1'b0, 1'b0);
        check("ab.nofd", 32'(frame_done), 0);

        // Reset asserted mid-RUN
        period_val = N'(3);
        bits_per_frame = N'(4);
        cyc(1'b1, 1'b0, 1'b0);                      // IDLE
        cyc(1'b0, 1'b0, 1'b0);                      // LOAD
        cyc(1'b0, 1'b0, 1'b0);                      // k0
        cyc(1'b0, 1'b0, 1'b0);                      // k1
        cyc(1'b0, 1'b0, 1'b0);                      // k2
        cyc(1'b0, 1'b0, 1'b1);                      // k3 tick
        cyc(1'b0, 1'b0, 1'b1);                      // k4, flag held high
        check("mr.pre.strobe", 32'(shift_strobe), 1);
        check("mr.pre.idx",    32'(bit_idx), 1);
        RST = 1'b1;
        #1;
        chk_idle("mr.rst");
        check("mr.rst.strobe", 32'(shift_strobe), 0);
        check("mr.rst.idx",    32'(bit_idx), 0);
        check("mr.rst.rval",   32'(rollover_val), 0);
        @(negedge CLK);
        RST = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk_idle("mr.after");
        check("mr.after.strobe", 32'(shift_strobe), 0);

        // Back-to-back with start held, period 2, bits 2; last tick is T
        run_frame(2, 2, 1'b1, 1'b0);                // ends in DONE (T+1)
`ifdef FRAME_TICK_CTRL_CONT_EN
        cyc(1'b1, 1'b0, 1'b0);                      // T+2
        check("b2b.t2.ce",    32'(count_enable), 1);
        check("b2b.t2.clear", 32'(clear), 0);
        check("b2b.t2.idx",   32'(bit_idx), 0);
        check("b2b.t2.fd",    32'(frame_done), 0);
        cyc(1'b0, 1'b1, 1'b0);                      // abort second frame
        check("b2b.ab.strobe", 32'(shift_strobe), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("b2b.end");
`else
        cyc(1'b1, 1'b0, 1'b0);                      // T+2 IDLE
        chk_idle("b2b.t2");
        cyc(1'b0, 1'b0, 1'b0);                      // T+3 LOAD
        check("b2b.t3.clear", 32'(clear), 1);
        check("b2b.t3.ce",    32'(count_enable), 0);
        cyc(1'b0, 1'b1, 1'b0);                      // T+4 RUN, then abort
        check("b2b.t4.ce",    32'(count_enable), 1);
        check("b2b.t4.clear", 32'(clear), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("b2b.end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
